uart_fifo_controller: RTL and testbench
=======================================

// Module: uart_fifo_controller
// PURPOSE
//  Parametrised UART between the FT2232 serial link and the 6809 bus; successor to the fixed 8N1 9600 block.
//  Single clock domain: baud and oversample timing are clock-enable ticks, not derived clocks.
//  Adds 16x oversampled RX with mid-bit sampling, TX/RX FIFOs, sticky error flags and maskable IRQ.
//  The 6809 bus decoder drives the FIFO strobes; o_IRQ goes to the CPU IRQ input.
// PARAMETERS
//  CLK_HZ      44330000  system clock frequency in Hz
//  BAUD        9600      line rate; tick divisor DIV = round(CLK_HZ/(BAUD*OVERSAMPLE)), DIV >= 2
//  OVERSAMPLE  16        ticks per bit, even, >= 8
//  DATA_BITS   8         data bits per frame, 5..8, sent LSB first
//  FIFO_DEPTH  16        entries per FIFO, power of two, >= 2
//  PARITY_ODD  0         parity sense (1 = odd, 0 = even); used only with UART_PARITY_EN
// PORTS
//  clk            in   1          system clock
//  reset          in   1          synchronous, active-high reset
//  i_UART_TX      in   1          serial data from host (asynchronous)
//  o_UART_RX      out  1          serial data to host; idles high
//  i_tx_data      in   DATA_BITS  byte to transmit
//  i_tx_wr        in   1          one-cycle strobe: push i_tx_data into TX FIFO
//  i_rx_rd        in   1          one-cycle strobe: pop RX FIFO head
//  o_rx_data      out  DATA_BITS  RX FIFO head (first-word fall-through); 0 when empty
//  i_irq_en       in   3          [0] RX data, [1] TX FIFO empty, [2] error
//  i_status_clr   in   1          one-cycle strobe: clear sticky flags
//  o_uart_status  out  8          see BEHAVIOUR
//  o_IRQ          out  1          active-low interrupt, registered
// BEHAVIOUR
//  Reset: o_UART_RX=1, o_IRQ=1, o_rx_data=0, both FIFOs empty, sticky flags 0, both FSMs IDLE, tick counter 0.
//  Tick: counter 0..DIV-1; one-clk tick at DIV-1. i_UART_TX passes through a 2-flop synchroniser (2-clk latency).
//  RX FSM IDLE->START->DATA->[PARITY]->STOP->IDLE:
//   IDLE: synced line low at a tick -> START; sub-tick counter = 0.
//   START: at tick OVERSAMPLE/2, line high -> IDLE (glitch, no flag); low -> DATA.
//   DATA: sample every OVERSAMPLE ticks (mid-bit), shift LSB-first, DATA_BITS samples.
//   STOP: sample low -> framing flag set, byte dropped; high -> push byte. Return to IDLE immediately (no wait for the bit end).
//   Push while RX full and no same-cycle pop -> byte dropped, overrun flag set.
//  TX FSM IDLE->START->DATA->[PARITY]->STOP->IDLE, each bit exactly OVERSAMPLE ticks:
//   IDLE with TX FIFO non-empty -> pop head, drive 0; back-to-back frames with no idle gap.
//  FIFOs: pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
//   Write when full: ignored. Read when empty: ignored.
//   Simultaneous push and pop: both happen, count unchanged (pop-then-push when full; push-only when empty).
//  o_uart_status (registered): [0] rx_avail, [1] tx_full, [2] tx_busy (FSM not IDLE), [3] overrun*, [4] framing*,
//   [5] parity_err*, [6] tx_empty (FIFO empty and FSM IDLE), [7] 0.  * = sticky, cleared by i_status_clr.
//   If clear and a set coincide, the set wins.
//  o_IRQ <= ~((en[0]&rx_avail) | (en[1]&tx_empty) | (en[2]&(status[3]|status[4]|status[5]))); one-clk latency.
//  Reset mid-frame: line returns high in the next cycle; partial frames are discarded.
// CONFIGURATION
//  UART_PARITY_EN defined: PARITY state after DATA in both FSMs. TX sends the parity bit per PARITY_ODD.
//   RX sets parity_err on mismatch and drops the byte; a framing error on the same frame also sets framing.
//  UART_PARITY_EN undefined: no PARITY state; frame is 1+DATA_BITS+1 bits; status[5] tied 0.
// STRUCTURE
//  Shared package uart_pkg: FSM state encodings; status bit index constants; clog2 function.
//  One sub-module, uart_sync_fifo (DEPTH, WIDTH): instantiated twice (TX and RX).
//  Tick generator, synchroniser and both FSMs live in this module.
// TESTING  (CLK_HZ=1600000, BAUD=10000, OVERSAMPLE=16 -> DIV=10, 160 clk/bit)
//  RX 8N1 0xA5, clean stop -> rx_avail=1, o_rx_data=0xA5, o_IRQ=0 with en=3'b001.
//   i_rx_rd -> rx_avail=0, o_IRQ=1.
//  Low glitch of 40 clk on i_UART_TX -> no push, no flags, RX FSM back to IDLE.
//  RX byte with stop bit=0 -> framing=1, FIFO empty. i_status_clr -> status[4]=0.
//  Write 0x55,0x0F back-to-back -> o_UART_RX shows 0,10101010,1,0,11110000,1 at 160 clk/bit, no gap.
//   tx_empty=1 after the last stop bit.
//  Write 17 bytes while TX is busy -> 16 stored, 17th ignored, tx_full=1. Send 17 RX frames without reads -> overrun=1, first 16 intact.
//  With UART_PARITY_EN, PARITY_ODD=0: TX 0x07 -> parity bit 1. RX 0x07 with parity 0 -> parity_err=1, byte dropped.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART bridge: FSM state encoding, status bit positions, clog2 helper.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_e;

  localparam int STAT_RX_AVAIL = 0;
  localparam int STAT_TX_FULL  = 1;
  localparam int STAT_TX_BUSY  = 2;
  localparam int STAT_OVERRUN  = 3;
  localparam int STAT_FRAMING  = 4;
  localparam int STAT_PARITY   = 5;
  localparam int STAT_TX_EMPTY = 6;

  // Idle block after reset: both FIFOs empty and TX FSM idle, so only tx_empty is set.
  localparam logic [7:0] STATUS_RESET = 8'h40;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; DEPTH must be a power of two.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_rd;
  logic             do_wr;

  // A write into a full FIFO is accepted only when the same cycle frees a slot.
  assign do_rd = rd & ~empty;
  assign do_wr = wr & (~full | do_rd);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_wr) - CNT_W'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/uart_fifo_controller.sv
// UART bridge between the FT2232 link and the 6809 bus: 16x oversampled RX, TX/RX FIFOs, sticky errors, IRQ.
// Define UART_PARITY_EN to add a parity bit after the data bits in both directions.
//
// state    | meaning (shared by RX and TX FSMs)
// S_IDLE   | line idle; RX waits for a low line, TX waits for FIFO data
// S_START  | start bit; RX confirms it at mid-bit
// S_DATA   | DATA_BITS data bits, LSB first
// S_PARITY | parity bit (UART_PARITY_EN only)
// S_STOP   | stop bit
module uart_fifo_controller
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 44330000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_UART_TX,
  output logic                 o_UART_RX,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 i_tx_wr,
  input  logic                 i_rx_rd,
  output logic [DATA_BITS-1:0] o_rx_data,
  input  logic [2:0]           i_irq_en,
  input  logic                 i_status_clr,
  output logic [7:0]           o_uart_status,
  output logic                 o_IRQ
);

  localparam int DIV   = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int DIV_W = clog2(DIV);
  localparam int OS_W  = clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [2:0]      BIT_LAST = 3'(DATA_BITS - 1);

  if (DIV < 2 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 8 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PARITY_ODD < 0 || PARITY_ODD > 1)
  begin : g_bad_params
    $error("uart_fifo_controller: unsupported parameter set");
  end

  logic [DIV_W-1:0]     tick_cnt;
  logic                 tick;
  logic                 sync_1;
  logic                 rx_line;

  uart_state_e          rx_state, rx_state_n;
  logic [OS_W-1:0]      rx_os, rx_os_n;
  logic [2:0]           rx_bit, rx_bit_n;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
  logic                 rx_push;
  logic                 set_frame;
  logic                 set_ovr;

  uart_state_e          tx_state, tx_state_n;
  logic [OS_W-1:0]      tx_os, tx_os_n;
  logic [2:0]           tx_bit, tx_bit_n;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
  logic                 tx_line, tx_line_n;
  logic                 tx_os_end;
  logic                 tx_load;
  logic                 tx_pop;

`ifdef UART_PARITY_EN
  logic                 rx_par_bad, rx_par_bad_n;
  logic                 set_par;
  logic                 tx_par, tx_par_n;
`endif

  logic [DATA_BITS-1:0] tx_head;
  logic [DATA_BITS-1:0] rx_head;
  logic                 tx_full, tx_empty_f;
  logic                 rx_full, rx_empty;
  logic [7:0]           status_q, status_n;
  logic                 irq_q;

  assign tick = (tick_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
      sync_1   <= 1'b1;
      rx_line  <= 1'b1;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + DIV_W'(1);
      sync_1   <= i_UART_TX;
      rx_line  <= sync_1;
    end
  end

  uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr      (i_tx_wr),
    .wr_data (i_tx_data),
    .rd      (tx_pop),
    .rd_data (tx_head),
    .full    (tx_full),
    .empty   (tx_empty_f)
  );

  uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr      (rx_push),
    .wr_data (rx_shift),
    .rd      (i_rx_rd),
    .rd_data (rx_head),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  always_comb begin
    rx_state_n = rx_state;
    rx_os_n    = rx_os;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_push    = 1'b0;
    set_frame  = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_bad_n = rx_par_bad;
    set_par      = 1'b0;
`endif
    case (rx_state)
      S_IDLE: begin
        if (tick && !rx_line) begin
          rx_state_n = S_START;
          rx_os_n    = '0;
        end
      end
      S_START: begin
        if (tick) begin
          if (rx_os == OS_HALF) begin
            rx_os_n    = '0;
            rx_bit_n   = '0;
            rx_state_n = rx_line ? S_IDLE : S_DATA;
`ifdef UART_PARITY_EN
            rx_par_bad_n = 1'b0;
`endif
          end else begin
            rx_os_n = rx_os + OS_W'(1);
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (rx_os == OS_LAST) begin
            rx_os_n    = '0;
            rx_shift_n = {rx_line, rx_shift[DATA_BITS-1:1]};
            rx_bit_n   = rx_bit + 3'd1;
            if (rx_bit == BIT_LAST) begin
`ifdef UART_PARITY_EN
              rx_state_n = S_PARITY;
`else
              rx_state_n = S_STOP;
`endif
            end
          end else begin
            rx_os_n = rx_os + OS_W'(1);
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          if (rx_os == OS_LAST) begin
            rx_os_n    = '0;
            rx_state_n = S_STOP;
            if (rx_line != (^rx_shift ^ (PARITY_ODD != 0))) begin
              rx_par_bad_n = 1'b1;
              set_par      = 1'b1;
            end
          end else begin
            rx_os_n = rx_os + OS_W'(1);
          end
        end
      end
`endif
      S_STOP: begin
        // Decide at mid stop bit and rearm at once, so the next start edge is never missed.
        if (tick) begin
          if (rx_os == OS_LAST) begin
            rx_os_n    = '0;
            rx_state_n = S_IDLE;
            if (!rx_line) begin
              set_frame = 1'b1;
            end else begin
`ifdef UART_PARITY_EN
              rx_push = !rx_par_bad;
`else
              rx_push = 1'b1;
`endif
            end
          end else begin
            rx_os_n = rx_os + OS_W'(1);
          end
        end
      end
      default: rx_state_n = S_IDLE;
    endcase
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_os_n    = tx_os;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_line_n  = tx_line;
    tx_pop     = 1'b0;
    tx_load    = 1'b0;
    tx_os_end  = tick && (tx_os == OS_LAST);
`ifdef UART_PARITY_EN
    tx_par_n   = tx_par;
`endif
    if (tick && tx_state != S_IDLE) tx_os_n = tx_os_end ? '0 : tx_os + OS_W'(1);
    case (tx_state)
      S_IDLE: tx_load = tick && !tx_empty_f;
      S_START: begin
        if (tx_os_end) begin
          tx_state_n = S_DATA;
          tx_bit_n   = '0;
          tx_line_n  = tx_shift[0];
        end
      end
      S_DATA: begin
        if (tx_os_end) begin
          if (tx_bit == BIT_LAST) begin
`ifdef UART_PARITY_EN
            tx_state_n = S_PARITY;
            tx_line_n  = tx_par;
`else
            tx_state_n = S_STOP;
            tx_line_n  = 1'b1;
`endif
          end else begin
            tx_bit_n   = tx_bit + 3'd1;
            tx_shift_n = tx_shift >> 1;
            tx_line_n  = tx_shift[1];
          end
        end
      end
      S_PARITY: begin
        if (tx_os_end) begin
          tx_state_n = S_STOP;
          tx_line_n  = 1'b1;
        end
      end
      S_STOP: begin
        if (tx_os_end) begin
          if (!tx_empty_f) tx_load = 1'b1;
          else tx_state_n = S_IDLE;
        end
      end
      default: begin
        tx_state_n = S_IDLE;
        tx_line_n  = 1'b1;
      end
    endcase
    // Loading from STOP chains frames with no idle gap.
    if (tx_load) begin
      tx_pop     = 1'b1;
      tx_shift_n = tx_head;
      tx_state_n = S_START;
      tx_line_n  = 1'b0;
      tx_os_n    = '0;
`ifdef UART_PARITY_EN
      tx_par_n   = ^tx_head ^ (PARITY_ODD != 0);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= S_IDLE;
      rx_os    <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      tx_state <= S_IDLE;
      tx_os    <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
`ifdef UART_PARITY_EN
      rx_par_bad <= 1'b0;
      tx_par     <= 1'b0;
`endif
    end else begin
      rx_state <= rx_state_n;
      rx_os    <= rx_os_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
      tx_state <= tx_state_n;
      tx_os    <= tx_os_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx_line  <= tx_line_n;
`ifdef UART_PARITY_EN
      rx_par_bad <= rx_par_bad_n;
      tx_par     <= tx_par_n;
`endif
    end
  end

  assign set_ovr = rx_push & rx_full & ~i_rx_rd;

  // Sticky bits: a set in the same cycle as a clear wins.
  always_comb begin
    status_n                = '0;
    status_n[STAT_RX_AVAIL] = ~rx_empty;
    status_n[STAT_TX_FULL]  = tx_full;
    status_n[STAT_TX_BUSY]  = (tx_state != S_IDLE);
    status_n[STAT_OVERRUN]  = set_ovr | (status_q[STAT_OVERRUN] & ~i_status_clr);
    status_n[STAT_FRAMING]  = set_frame | (status_q[STAT_FRAMING] & ~i_status_clr);
`ifdef UART_PARITY_EN
    status_n[STAT_PARITY]   = set_par | (status_q[STAT_PARITY] & ~i_status_clr);
`else
    status_n[STAT_PARITY]   = 1'b0;
`endif
    status_n[STAT_TX_EMPTY] = tx_empty_f & (tx_state == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status_q <= STATUS_RESET;
      irq_q    <= 1'b1;
    end else begin
      status_q <= status_n;
      irq_q    <= ~((i_irq_en[0] & status_q[STAT_RX_AVAIL]) |
                    (i_irq_en[1] & status_q[STAT_TX_EMPTY]) |
                    (i_irq_en[2] & (status_q[STAT_OVERRUN] | status_q[STAT_FRAMING] |
                                    status_q[STAT_PARITY])));
    end
  end

  assign o_UART_RX     = tx_line;
  assign o_rx_data     = rx_empty ? '0 : rx_head;
  assign o_uart_status = status_q;
  assign o_IRQ         = irq_q;

endmodule

// File: tb/tb_uart_fifo_controller.sv
// Directed bench for uart_fifo_controller at DIV=10, 160 clk per bit; parity cases run with UART_PARITY_EN.
module tb_uart_fifo_controller;
  import uart_pkg::*;

  localparam int BIT_CLKS = 160;
  localparam int HALF_BIT = 80;
`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
  localparam logic [31:0] EXP_F55 = 32'h4AA;
  localparam logic [31:0] EXP_F0F = 32'h41E;
  localparam logic [31:0] EXP_F07 = 32'h60E;
  logic par_flip = 1'b0;
`else
  localparam int FRAME_BITS = 10;
  localparam logic [31:0] EXP_F55 = 32'h2AA;
  localparam logic [31:0] EXP_F0F = 32'h21E;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       i_UART_TX;
  logic       o_UART_RX;
  logic [7:0] i_tx_data;
  logic       i_tx_wr;
  logic       i_rx_rd;
  logic [7:0] o_rx_data;
  logic [2:0] i_irq_en;
  logic       i_status_clr;
  logic [7:0] o_uart_status;
  logic       o_IRQ;

  int n_checks = 0;
  int n_fail   = 0;

  uart_fifo_controller #(
    .CLK_HZ(1600000), .BAUD(10000), .OVERSAMPLE(16),
    .DATA_BITS(8), .FIFO_DEPTH(16), .PARITY_ODD(0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_UART_TX     (i_UART_TX),
    .o_UART_RX     (o_UART_RX),
    .i_tx_data     (i_tx_data),
    .i_tx_wr       (i_tx_wr),
    .i_rx_rd       (i_rx_rd),
    .o_rx_data     (o_rx_data),
    .i_irq_en      (i_irq_en),
    .i_status_clr  (i_status_clr),
    .o_uart_status (o_uart_status),
    .o_IRQ         (o_IRQ)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    i_UART_TX = 1'b0;
    clk_wait(BIT_CLKS);
    for (int j = 0; j < 8; j++) begin
      i_UART_TX = data[j];
      clk_wait(BIT_CLKS);
    end
`ifdef UART_PARITY_EN
    i_UART_TX = ^data ^ par_flip;
    clk_wait(BIT_CLKS);
`endif
    i_UART_TX = stop;
    clk_wait(BIT_CLKS);
    i_UART_TX = 1'b1;
  endtask

  task automatic pulse_rd();
    i_rx_rd = 1'b1;
    clk_wait(1);
    i_rx_rd = 1'b0;
  endtask

  task automatic pulse_clr();
    i_status_clr = 1'b1;
    clk_wait(1);
    i_status_clr = 1'b0;
  endtask

  task automatic write_tx(input logic [7:0] data);
    i_tx_data = data;
    i_tx_wr   = 1'b1;
    clk_wait(1);
    i_tx_wr   = 1'b0;
  endtask

  // Waits (bounded) for the start edge, then samples every bit at its centre.
  task automatic capture_line(input int nbits, output logic [31:0] bits);
    int waited;
    waited = 0;
    bits   = '0;
    while (o_UART_RX !== 1'b0 && waited < 100) begin
      clk_wait(1);
      waited++;
    end
    check_val("tx start edge seen", 32'(o_UART_RX === 1'b0), 32'd1);
    for (int i = 0; i < nbits; i++) begin
      clk_wait(HALF_BIT);
      bits[i] = o_UART_RX;
      clk_wait(BIT_CLKS - HALF_BIT);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] bits;
    logic [31:0] mask;
    reset = 1'b1; i_UART_TX = 1'b1; i_tx_data = '0; i_tx_wr = 1'b0;
    i_rx_rd = 1'b0; i_irq_en = 3'b000; i_status_clr = 1'b0;
    mask = (32'd1 << FRAME_BITS) - 32'd1;
    clk_wait(5);
    reset = 1'b0;
    clk_wait(3);
    check_val("reset line", 32'(o_UART_RX), 32'd1);
    check_val("reset irq", 32'(o_IRQ), 32'd1);
    check_val("reset rx_data", 32'(o_rx_data), 32'd0);
    check_val("reset status", 32'(o_uart_status), 32'h40);

    // Clean RX byte raises rx_avail and the RX interrupt
    i_irq_en = 3'b001;
    send_frame(8'hA5, 1'b1);
    clk_wait(5);
    check_val("rx avail", 32'(o_uart_status[0]), 32'd1);
    check_val("rx data A5", 32'(o_rx_data), 32'hA5);
    check_val("rx irq low", 32'(o_IRQ), 32'd0);
    pulse_rd();
    clk_wait(4);
    check_val("rx avail after read", 32'(o_uart_status[0]), 32'd0);
    check_val("rx irq released", 32'(o_IRQ), 32'd1);
    check_val("rx data empty", 32'(o_rx_data), 32'd0);
    i_irq_en = 3'b000;

    // 40-clk low glitch is rejected at mid start bit
    i_UART_TX = 1'b0;
    clk_wait(40);
    i_UART_TX = 1'b1;
    clk_wait(300);
    check_val("glitch status", 32'(o_uart_status), 32'h40);
    check_val("glitch rx idle", 32'(dut.rx_state), 32'(S_IDLE));

    // Stop bit low -> framing flag, byte dropped
    send_frame(8'h3C, 1'b0);
    clk_wait(400);
    check_val("framing set", 32'(o_uart_status[4]), 32'd1);
    check_val("framing drops byte", 32'(o_uart_status[0]), 32'd0);
    pulse_clr();
    clk_wait(3);
    check_val("framing cleared", 32'(o_uart_status[4]), 32'd0);

    // Back-to-back TX frames
    i_tx_data = 8'h55;
    i_tx_wr   = 1'b1;
    clk_wait(1);
    i_tx_data = 8'h0F;
    clk_wait(1);
    i_tx_wr   = 1'b0;
    capture_line(2 * FRAME_BITS, bits);
    check_val("tx frame 55", bits & mask, EXP_F55);
    check_val("tx frame 0F", (bits >> FRAME_BITS) & mask, EXP_F0F);
    clk_wait(5);
    check_val("tx empty after stop", 32'(o_uart_status[6]), 32'd1);
    check_val("tx not busy", 32'(o_uart_status[2]), 32'd0);

`ifdef UART_PARITY_EN
    write_tx(8'h07);
    capture_line(FRAME_BITS, bits);
    check_val("tx frame 07 parity", bits & mask, EXP_F07);
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    par_flip = 1'b0;
    clk_wait(5);
    check_val("parity err set", 32'(o_uart_status[5]), 32'd1);
    check_val("parity drops byte", 32'(o_uart_status[0]), 32'd0);
    pulse_clr();
    clk_wait(3);
`endif

    // TX FIFO overflow while the transmitter is busy
    write_tx(8'h00);
    clk_wait(20);
    for (int i = 0; i < 17; i++) begin
      i_tx_data = 8'h11 + 8'(i);
      i_tx_wr   = 1'b1;
      clk_wait(1);
    end
    i_tx_wr = 1'b0;
    clk_wait(3);
    check_val("tx full", 32'(o_uart_status[1]), 32'd1);
    check_val("tx busy", 32'(o_uart_status[2]), 32'd1);
    check_val("tx head kept", 32'(dut.tx_head), 32'h11);
    check_val("tx line low mid frame", 32'(o_UART_RX), 32'd0);
    reset = 1'b1;
    clk_wait(1);
    check_val("reset mid frame line", 32'(o_UART_RX), 32'd1);
    reset = 1'b0;
    clk_wait(3);
    check_val("status after reset", 32'(o_uart_status), 32'h40);

    // RX overrun: 17 frames without reads
    i_irq_en = 3'b100;
    for (int i = 0; i < 16; i++) send_frame(8'h80 + 8'(i), 1'b1);
    clk_wait(5);
    check_val("no overrun at 16", 32'(o_uart_status[3]), 32'd0);
    check_val("irq idle at 16", 32'(o_IRQ), 32'd1);
    send_frame(8'hEE, 1'b1);
    clk_wait(5);
    check_val("overrun set", 32'(o_uart_status[3]), 32'd1);
    check_val("overrun irq", 32'(o_IRQ), 32'd0);
    for (int i = 0; i < 16; i++) begin
      check_val($sformatf("rx fifo[%0d]", i), 32'(o_rx_data), 32'h80 + 32'(i));
      pulse_rd();
    end
    clk_wait(3);
    check_val("rx drained", 32'(o_uart_status[0]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
